biu_bus_ctrl: RTL and testbench

Bus-cycle sequencer and arbiter for the 8088 bus interface bank. It runs the T1–T4 bus state machine that drives ALE, RD, WR, DEN, DTR and IOM, and shares the bus between four sources: execution-unit data requests, instruction prefetch into the 4-byte queue, interrupt-acknowledge and external HOLD. It also programs the address generator (OP, SEG_SEL, M1_SEL, DESP) and owns the prefetch IP and the queue-occupancy count.

---
 rtl/biu_pkg.sv | 22 ++
 rtl/biu_prefetch_ptr.sv | 57 +++++
 rtl/biu_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_biu_bus_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// Shared types for the 8088 bus interface bank: bus states, cycle kinds,
// segment selectors and the default instruction-queue depth.
package biu_pkg;
  localparam int QUEUE_DEPTH_DEF = 4;

  typedef enum logic [2:0] {TI, T1, T2, T3, TW, T4, TH} bus_state_t;
  typedef enum logic [2:0] {FETCH, MEM_RD, MEM_WR, IO_RD, IO_WR, INTA_CYC} cyc_t;

  localparam logic [1:0] SEG_CS = 2'b00;
  localparam logic [1:0] SEG_DS = 2'b01;
  localparam logic [1:0] SEG_ES = 2'b10;
  localparam logic [1:0] SEG_SS = 2'b11;

  function automatic cyc_t eu_cyc(input logic wr, input logic io);
    case ({io, wr})
      2'b00:   return MEM_RD;
      2'b01:   return MEM_WR;
      2'b10:   return IO_RD;
      default: return IO_WR;
    endcase
  endfunction
endpackage

// File: rtl/biu_prefetch_ptr.sv
// Prefetch pointer and queue-occupancy tracking; decides whether another
// instruction fetch may be started.
module biu_prefetch_ptr import biu_pkg::*; #(
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        queue_ena_i,
  input  logic        q_pop_i,
  input  logic        q_flush_i,
  input  logic [15:0] flush_ip_i,
  input  logic        fetch_busy_i,
  output logic [15:0] ip_o,
  output logic        queue_clr_o,
  output logic        fetch_ok_o
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      ip_q, ip_d;
  logic             clr_q;
  logic             pop_eff;

  assign pop_eff = q_pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    ip_d    = ip_q;
    if (q_flush_i) begin
      count_d = '0;
      ip_d    = flush_ip_i;
    end else begin
      if (queue_ena_i) ip_d = ip_q + 16'd1;
      if (queue_ena_i && !q_pop_i && (count_q != CNT_W'(QUEUE_DEPTH)))
        count_d = count_q + CNT_W'(1);
      else if (!queue_ena_i && pop_eff)
        count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ip_q    <= '0;
      clr_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ip_q    <= ip_d;
      clr_q   <= q_flush_i;
    end
  end

  // A fetch already on the bus reserves its queue slot before it lands.
  assign fetch_ok_o  = ((int'(count_q) + int'(fetch_busy_i)) < QUEUE_DEPTH) && !q_flush_i;
  assign ip_o        = ip_q;
  assign queue_clr_o = clr_q;
endmodule

// File: rtl/biu_bus_ctrl.sv
// 8088 bus-cycle sequencer (T1..T4/TW/TH) with HOLD/INTA/EU/prefetch
// arbitration and address-generator programming.
module biu_bus_ctrl import biu_pkg::*; #(
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eu_req_i,
  input  logic        eu_wr_i,
  input  logic        eu_io_i,
  input  logic [1:0]  eu_seg_i,
  input  logic [2:0]  eu_m1_i,
  input  logic [15:0] eu_desp_i,
  input  logic [7:0]  eu_wdata_i,
  output logic        eu_ack_o,
  output logic [7:0]  eu_rdata_o,
  input  logic        q_pop_i,
  input  logic        q_flush_i,
  input  logic [15:0] flush_ip_i,
  output logic [15:0] ip_o,
  output logic        queue_ena_o,
  output logic        queue_clr_o,
  output logic        op_o,
  output logic [1:0]  seg_sel_o,
  output logic [2:0]  m1_sel_o,
  output logic [15:0] desp_o,
  output logic        ale_o,
  output logic        rd_o,
  output logic        wr_o,
  output logic        den_o,
  output logic        dtr_o,
  output logic        iom_o,
  output logic        ad_oe_o,
  output logic [7:0]  ad_do_o,
  input  logic [7:0]  ad_di_i,
  input  logic        ready_i,
  input  logic        hold_i,
  output logic        hlda_o,
  input  logic        intr_i,
  output logic        inta_o,
  output logic [7:0]  int_vec_o,
  output logic        int_vld_o
);
  bus_state_t  state_q;
  cyc_t        cyc_q, arb_cyc;
  logic        kill_q, armed_q;
  logic        ale_q, rd_q, wr_q, den_q, dtr_q, iom_q, ad_oe_q, hlda_q, inta_q;
  logic        queue_ena_q, eu_ack_q, int_vld_q, op_q;
  logic [1:0]  seg_sel_q;
  logic [2:0]  m1_sel_q;
  logic [15:0] desp_q;
  logic [7:0]  ad_do_q, eu_rdata_q, int_vec_q;
  logic        fetch_busy, fetch_ok, data_req, arb_go, arb_hold, cyc_is_wr;

  biu_prefetch_ptr #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_pf (
    .clk          (clk),
    .rst_n        (rst_n),
    .queue_ena_i  (queue_ena_q),
    .q_pop_i      (q_pop_i),
    .q_flush_i    (q_flush_i),
    .flush_ip_i   (flush_ip_i),
    .fetch_busy_i (fetch_busy),
    .ip_o         (ip_o),
    .queue_clr_o  (queue_clr_o),
    .fetch_ok_o   (fetch_ok)
  );

  assign fetch_busy = (cyc_q == FETCH) && !kill_q && (state_q != TI) && (state_q != TH);
  // EU_REQ is still high during the T4 that acknowledges it; do not restart it.
  assign data_req   = eu_req_i && !((state_q == T4) && (cyc_q != FETCH) && (cyc_q != INTA_CYC));
  assign cyc_is_wr  = (cyc_q == MEM_WR) || (cyc_q == IO_WR);

  always_comb begin
    arb_go   = 1'b1;
    arb_hold = 1'b0;
    arb_cyc  = FETCH;
    if (hold_i) begin
      arb_hold = 1'b1;
      arb_go   = 1'b0;
    end else if (intr_i && armed_q) arb_cyc = INTA_CYC;
    else if (data_req)              arb_cyc = eu_cyc(eu_wr_i, eu_io_i);
    else if (!fetch_ok)             arb_go  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TI;          cyc_q <= FETCH;       kill_q <= 1'b0;  armed_q <= 1'b1;
      ale_q <= 1'b0;          rd_q <= 1'b1;         wr_q <= 1'b1;    den_q <= 1'b1;
      dtr_q <= 1'b0;          iom_q <= 1'b0;        ad_oe_q <= 1'b0; ad_do_q <= '0;
      hlda_q <= 1'b0;         inta_q <= 1'b0;       queue_ena_q <= 1'b0;
      eu_ack_q <= 1'b0;       int_vld_q <= 1'b0;    op_q <= 1'b0;    seg_sel_q <= SEG_CS;
      m1_sel_q <= '0;         desp_q <= '0;         eu_rdata_q <= '0; int_vec_q <= '0;
    end else begin
      ale_q       <= 1'b0;
      queue_ena_q <= 1'b0;
      eu_ack_q    <= 1'b0;
      int_vld_q   <= 1'b0;
      if (!intr_i) armed_q <= 1'b1;
      if (q_flush_i && (state_q inside {T1, T2, T3, TW})) kill_q <= 1'b1;
      case (state_q)
        TI, T4: begin
          rd_q <= 1'b1; wr_q <= 1'b1; den_q <= 1'b1; ad_oe_q <= 1'b0; inta_q <= 1'b0;
          if (arb_hold) begin
            state_q <= TH; hlda_q <= 1'b1; dtr_q <= 1'b0; iom_q <= 1'b0;
          end else if (arb_go) begin
            state_q <= T1;
            cyc_q   <= arb_cyc;
            ale_q   <= 1'b1;
            kill_q  <= 1'b0;
            dtr_q   <= 1'b0;
            iom_q   <= (arb_cyc == IO_RD) || (arb_cyc == IO_WR);
            if (arb_cyc == FETCH) op_q <= 1'b0;
            else if (arb_cyc != INTA_CYC) begin
              op_q <= 1'b1; seg_sel_q <= eu_seg_i; m1_sel_q <= eu_m1_i; desp_q <= eu_desp_i;
            end
          end else begin
            state_q <= TI; dtr_q <= 1'b0; iom_q <= 1'b0;
          end
        end
        // Strobe phase: direction and data driver set up for the transfer.
        T1: begin
          state_q <= T2;
          den_q   <= 1'b0;
          if (cyc_q == INTA_CYC) inta_q <= 1'b1;
          else if (cyc_is_wr) begin
            wr_q <= 1'b0; dtr_q <= 1'b1; ad_oe_q <= 1'b1; ad_do_q <= eu_wdata_i;
          end else rd_q <= 1'b0;
        end
        T2: state_q <= T3;
        T3, TW: begin
          if (!ready_i) state_q <= TW;
          else begin
            state_q <= T4;
            rd_q <= 1'b1; wr_q <= 1'b1; den_q <= 1'b1; ad_oe_q <= 1'b0; inta_q <= 1'b0;
            case (cyc_q)
              FETCH:         queue_ena_q <= !kill_q && !q_flush_i;
              INTA_CYC:      begin int_vec_q <= ad_di_i; int_vld_q <= 1'b1; armed_q <= 1'b0; end
              MEM_RD, IO_RD: begin eu_rdata_q <= ad_di_i; eu_ack_q <= 1'b1; end
              default:       eu_ack_q <= 1'b1;
            endcase
          end
        end
        TH: if (!hold_i) begin state_q <= TI; hlda_q <= 1'b0; end
        default: state_q <= TI;
      endcase
    end
  end

  assign eu_ack_o = eu_ack_q;    assign eu_rdata_o = eu_rdata_q;  assign queue_ena_o = queue_ena_q;
  assign op_o = op_q;            assign seg_sel_o = seg_sel_q;    assign m1_sel_o = m1_sel_q;
  assign desp_o = desp_q;        assign ale_o = ale_q;            assign rd_o = rd_q;
  assign wr_o = wr_q;            assign den_o = den_q;            assign dtr_o = dtr_q;
  assign iom_o = iom_q;          assign ad_oe_o = ad_oe_q;        assign ad_do_o = ad_do_q;
  assign hlda_o = hlda_q;        assign inta_o = inta_q;          assign int_vec_o = int_vec_q;
  assign int_vld_o = int_vld_q;
endmodule

// File: tb/tb_biu_bus_ctrl.sv
// Scenario bench for biu_bus_ctrl: directed bus-cycle scenarios plus randomized
// EU transfers checked against a cycle-count/queue-occupancy reference model.
module tb_biu_bus_ctrl;
  import biu_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  logic eu_req, eu_wr, eu_io, q_pop, q_flush, ready, hold, intr;
  logic [1:0] eu_seg;
  logic [2:0] eu_m1;
  logic [15:0] eu_desp, flush_ip;
  logic [7:0] eu_wdata, ad_di;
  logic eu_ack_o, queue_ena_o, queue_clr_o, op_o, ale_o, rd_o, wr_o, den_o, dtr_o, iom_o;
  logic ad_oe_o, hlda_o, inta_o, int_vld_o;
  logic [7:0] eu_rdata_o, ad_do_o, int_vec_o;
  logic [15:0] ip_o, desp_o;
  logic [1:0] seg_sel_o;
  logic [2:0] m1_sel_o;

  int n_checks = 0, n_fail = 0;
  int model_count = 0;
  logic [7:0] model_rdata = 8'h00;

  always #5 clk = ~clk;

  biu_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .eu_req_i(eu_req), .eu_wr_i(eu_wr), .eu_io_i(eu_io),
    .eu_seg_i(eu_seg), .eu_m1_i(eu_m1), .eu_desp_i(eu_desp), .eu_wdata_i(eu_wdata),
    .eu_ack_o(eu_ack_o), .eu_rdata_o(eu_rdata_o), .q_pop_i(q_pop), .q_flush_i(q_flush),
    .flush_ip_i(flush_ip), .ip_o(ip_o), .queue_ena_o(queue_ena_o), .queue_clr_o(queue_clr_o),
    .op_o(op_o), .seg_sel_o(seg_sel_o), .m1_sel_o(m1_sel_o), .desp_o(desp_o), .ale_o(ale_o),
    .rd_o(rd_o), .wr_o(wr_o), .den_o(den_o), .dtr_o(dtr_o), .iom_o(iom_o), .ad_oe_o(ad_oe_o),
    .ad_do_o(ad_do_o), .ad_di_i(ad_di), .ready_i(ready), .hold_i(hold), .hlda_o(hlda_o),
    .intr_i(intr), .inta_o(inta_o), .int_vec_o(int_vec_o), .int_vld_o(int_vld_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    eu_req = 0; eu_wr = 0; eu_io = 0; eu_seg = 0; eu_m1 = 0; eu_desp = 0; eu_wdata = 0;
    q_pop = 0; q_flush = 0; flush_ip = 0; ad_di = 0; ready = 1; hold = 0; intr = 0;
    rst_n = 0;
    repeat (2) tick();
    n_checks++;
    if ({ale_o, rd_o, wr_o, den_o, dtr_o, iom_o, ad_oe_o, hlda_o, inta_o} !== 9'b0_1110_0000) begin
      n_fail++; $display("FAIL reset_bus got=%b exp=%b", {ale_o, rd_o, wr_o, den_o, dtr_o, iom_o, ad_oe_o, hlda_o, inta_o}, 9'b0_1110_0000);
    end
    n_checks++;
    if ({queue_ena_o, queue_clr_o, eu_ack_o, int_vld_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulses got=%b exp=0000", {queue_ena_o, queue_clr_o, eu_ack_o, int_vld_o});
    end
    n_checks++;
    if ({ip_o, op_o, seg_sel_o, m1_sel_o, desp_o} !== 38'd0) begin
      n_fail++; $display("FAIL reset_agen got=%h exp=0", {ip_o, op_o, seg_sel_o, m1_sel_o, desp_o});
    end
    n_checks++;
    if ({eu_rdata_o, int_vec_o} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0000", {eu_rdata_o, int_vec_o});
    end
    // Empty queue after reset: a fetch starts right away; reset it in T2.
    rst_n = 1;
    tick();
    n_checks++;
    if ({ale_o, op_o} !== 2'b10) begin
      n_fail++; $display("FAIL first_fetch_t1 got=%b exp=10", {ale_o, op_o});
    end
    tick();
    n_checks++;
    if (rd_o !== 1'b0) begin
      n_fail++; $display("FAIL first_fetch_t2_rd got=%b exp=0", rd_o);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({rd_o, den_o, ale_o} !== 3'b110) begin
      n_fail++; $display("FAIL midcycle_reset got=%b exp=110", {rd_o, den_o, ale_o});
    end
    tick();
  endtask

  task automatic test_eu_read();
    eu_req = 1; eu_wr = 0; eu_io = 0; eu_seg = SEG_DS; eu_m1 = 3'b001; eu_desp = 16'h0100;
    ad_di = 8'h5A; ready = 1;
    rst_n = 1;
    tick();
    n_checks++;
    if ({ale_o, op_o, seg_sel_o, m1_sel_o, desp_o, iom_o} !== {1'b1, 1'b1, 2'b01, 3'b001, 16'h0100, 1'b0}) begin
      n_fail++; $display("FAIL rd_t1 got=%h exp=%h", {ale_o, op_o, seg_sel_o, m1_sel_o, desp_o, iom_o}, {1'b1, 1'b1, 2'b01, 3'b001, 16'h0100, 1'b0});
    end
    tick();
    n_checks++;
    if ({ale_o, rd_o, wr_o, den_o, dtr_o} !== 5'b00100) begin
      n_fail++; $display("FAIL rd_t2 got=%b exp=00100", {ale_o, rd_o, wr_o, den_o, dtr_o});
    end
    tick();
    n_checks++;
    if ({rd_o, eu_ack_o} !== 2'b00) begin
      n_fail++; $display("FAIL rd_t3 got=%b exp=00", {rd_o, eu_ack_o});
    end
    tick();
    n_checks++;
    if ({eu_ack_o, rd_o, den_o, eu_rdata_o} !== {3'b111, 8'h5A}) begin
      n_fail++; $display("FAIL rd_t4 got=%h exp=%h", {eu_ack_o, rd_o, den_o, eu_rdata_o}, {3'b111, 8'h5A});
    end
    model_rdata = 8'h5A;
    eu_req = 0;
  endtask

  task automatic test_prefetch();
    logic [7:0] bytes_q[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [15:0] exp_ip = 16'h0000;
    int pushes = 0, fetches = 0, last_ale = -1;
    bit spacing_ok = 1;
    ad_di = bytes_q[0];
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ale_o && !op_o) begin
        n_checks++;
        if (ip_o !== exp_ip) begin
          n_fail++; $display("FAIL fetch_ip got=%h exp=%h", ip_o, exp_ip);
        end
        if (last_ale >= 0 && (c - last_ale) != 4) spacing_ok = 0;
        last_ale = c;
        fetches++;
      end
      if (queue_ena_o) begin
        exp_ip++;
        pushes++;
        model_count++;
        ad_di = bytes_q[pushes % 4];
      end
    end
    n_checks++;
    if (pushes !== QUEUE_DEPTH_DEF) begin
      n_fail++; $display("FAIL fill_pushes got=%0d exp=%0d", pushes, QUEUE_DEPTH_DEF);
    end
    n_checks++;
    if (spacing_ok !== 1'b1) begin
      n_fail++; $display("FAIL back_to_back got=%b exp=1", spacing_ok);
    end
    n_checks++;
    if (ip_o !== 16'd4) begin
      n_fail++; $display("FAIL fill_ip got=%h exp=0004", ip_o);
    end
    q_pop = 1;
    tick();
    q_pop = 0;
    model_count--;
    fetches = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ale_o && !op_o) begin
        fetches++;
        n_checks++;
        if (ip_o !== exp_ip) begin
          n_fail++; $display("FAIL refill_ip got=%h exp=%h", ip_o, exp_ip);
        end
      end
      if (queue_ena_o) begin exp_ip++; model_count++; end
    end
    n_checks++;
    if (fetches !== QUEUE_DEPTH_DEF - 3) begin
      n_fail++; $display("FAIL refill_count got=%0d exp=1", fetches);
    end
    n_checks++;
    if (ip_o !== 16'd5) begin
      n_fail++; $display("FAIL refill_ip_end got=%h exp=0005", ip_o);
    end
  endtask

  task automatic test_wait_write();
    int wr_low = 0, ack_at = -1;
    eu_req = 1; eu_wr = 1; eu_io = 0; eu_wdata = 8'hAA; eu_seg = SEG_ES; eu_m1 = 3'b101;
    eu_desp = 16'h1234;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ready = !(k == 3 || k == 4);
      if (k == 1) begin
        n_checks++;
        if ({ale_o, op_o, seg_sel_o, m1_sel_o, desp_o} !== {2'b11, 2'b10, 3'b101, 16'h1234}) begin
          n_fail++; $display("FAIL wr_t1 got=%h exp=%h", {ale_o, op_o, seg_sel_o, m1_sel_o, desp_o}, {2'b11, 2'b10, 3'b101, 16'h1234});
        end
      end
      if (k == 2) begin
        n_checks++;
        if ({rd_o, dtr_o, ad_oe_o, den_o, ad_do_o} !== {4'b1110, 8'hAA}) begin
          n_fail++; $display("FAIL wr_t2 got=%h exp=%h", {rd_o, dtr_o, ad_oe_o, den_o, ad_do_o}, {4'b1110, 8'hAA});
        end
      end
      if (!wr_o) wr_low++;
      if (eu_ack_o && ack_at < 0) begin ack_at = k; eu_req = 0; end
    end
    eu_req = 0; ready = 1;
    n_checks++;
    if (wr_low !== 4) begin
      n_fail++; $display("FAIL wr_low_cycles got=%0d exp=4", wr_low);
    end
    n_checks++;
    if (ack_at !== 6) begin
      n_fail++; $display("FAIL wr_ack_cycle got=%0d exp=6", ack_at);
    end
  endtask

  task automatic test_hold_fetch();
    bit found = 0, done = 0, held_ok = 1;
    q_pop = 1;
    tick();
    q_pop = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (ale_o && !op_o) found = 1;
    end
    n_checks++;
    if (!found || ip_o !== 16'd5) begin
      n_fail++; $display("FAIL hold_fetch_start got=%b/%h exp=1/0005", found, ip_o);
    end
    hold = 1;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (queue_ena_o) done = 1;
      if (hlda_o) held_ok = 0;
    end
    n_checks++;
    if (!done || !held_ok) begin
      n_fail++; $display("FAIL hold_fetch_completes got=%b%b exp=11", done, held_ok);
    end
    tick();
    n_checks++;
    if ({hlda_o, ale_o, rd_o, ad_oe_o} !== 4'b1010) begin
      n_fail++; $display("FAIL hlda_rise got=%b exp=1010", {hlda_o, ale_o, rd_o, ad_oe_o});
    end
    held_ok = 1;
    repeat (3) begin
      tick();
      if (!hlda_o || ale_o) held_ok = 0;
    end
    n_checks++;
    if (held_ok !== 1'b1) begin
      n_fail++; $display("FAIL hold_stays got=%b exp=1", held_ok);
    end
    hold = 0;
    tick();
    n_checks++;
    if (hlda_o !== 1'b0) begin
      n_fail++; $display("FAIL hlda_fall got=%b exp=0", hlda_o);
    end
    repeat (4) tick();
  endtask

  task automatic test_intr();
    int vlds = 0;
    intr = 1; ad_di = 8'h08;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) begin
        n_checks++;
        if ({ale_o, iom_o} !== 2'b10) begin
          n_fail++; $display("FAIL inta_t1 got=%b exp=10", {ale_o, iom_o});
        end
      end
      if (k == 2) begin
        n_checks++;
        if ({inta_o, rd_o, den_o} !== 3'b110) begin
          n_fail++; $display("FAIL inta_t2 got=%b exp=110", {inta_o, rd_o, den_o});
        end
      end
      if (k == 4) begin
        n_checks++;
        if ({int_vld_o, int_vec_o, inta_o} !== {1'b1, 8'h08, 1'b0}) begin
          n_fail++; $display("FAIL inta_t4 got=%h exp=%h", {int_vld_o, int_vec_o, inta_o}, {1'b1, 8'h08, 1'b0});
        end
      end
      if (int_vld_o) vlds++;
    end
    n_checks++;
    if (vlds !== 1) begin
      n_fail++; $display("FAIL inta_once got=%0d exp=1", vlds);
    end
    intr = 0;
    tick();
    intr = 1; ad_di = 8'h21; vlds = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (int_vld_o) vlds++;
    end
    intr = 0;
    n_checks++;
    if (vlds !== 1 || int_vec_o !== 8'h21) begin
      n_fail++; $display("FAIL inta_rearm got=%0d/%h exp=1/21", vlds, int_vec_o);
    end
    tick();
  endtask

  task automatic test_flush();
    bit found = 0;
    logic [15:0] ips[$];
    int pushes = 0;
    q_pop = 1;
    tick();
    q_pop = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (ale_o && !op_o) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL flush_fetch_start got=0 exp=1");
    end
    tick();
    tick();
    q_flush = 1; flush_ip = 16'hFFFF;
    tick();
    q_flush = 0;
    model_count = 0;
    n_checks++;
    if ({queue_ena_o, queue_clr_o, ip_o} !== {2'b01, 16'hFFFF}) begin
      n_fail++; $display("FAIL flush_t4 got=%h exp=%h", {queue_ena_o, queue_clr_o, ip_o}, {2'b01, 16'hFFFF});
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 0) begin
        n_checks++;
        if (queue_clr_o !== 1'b0) begin
          n_fail++; $display("FAIL clr_pulse_width got=%b exp=0", queue_clr_o);
        end
      end
      if (ale_o && !op_o) ips.push_back(ip_o);
      if (queue_ena_o) begin pushes++; model_count++; end
    end
    n_checks++;
    if (ips.size() < 2 || ips[0] !== 16'hFFFF || ips[1] !== 16'h0000) begin
      n_fail++; $display("FAIL flush_ip_seq got=%0d fetches first=%h exp=FFFF,0000", ips.size(), (ips.size() > 0) ? ips[0] : 16'hxxxx);
    end
    n_checks++;
    if (pushes !== QUEUE_DEPTH_DEF || ip_o !== 16'h0003) begin
      n_fail++; $display("FAIL flush_refill got=%0d/%h exp=4/0003", pushes, ip_o);
    end
  endtask

  task automatic test_random_eu();
    logic wr, io;
    logic [1:0] seg;
    logic [2:0] m1;
    logic [15:0] desp;
    logic [7:0] wd, di;
    int w, ack_at;
    for (int it = 0; it < 12; it++) begin
      wr = 1'($urandom_range(0, 1)); io = 1'($urandom_range(0, 1));
      seg = 2'($urandom); m1 = 3'($urandom); desp = 16'($urandom);
      wd = 8'($urandom); di = 8'($urandom); w = int'($urandom_range(0, 3));
      if (it == 1) seg = SEG_SS;
      eu_req = 1; eu_wr = wr; eu_io = io; eu_seg = seg; eu_m1 = m1; eu_desp = desp;
      eu_wdata = wd; ad_di = di; ready = 1; ack_at = -1;
      for (int k = 1; k <= 8 + w; k++) begin
        tick();
        ready = !(k >= 3 && k < 3 + w);
        if (k == 1) begin
          n_checks++;
          if ({ale_o, op_o, seg_sel_o, m1_sel_o, desp_o, iom_o} !== {2'b11, seg, m1, desp, io}) begin
            n_fail++; $display("FAIL rnd_t1[%0d] got=%h exp=%h", it, {ale_o, op_o, seg_sel_o, m1_sel_o, desp_o, iom_o}, {2'b11, seg, m1, desp, io});
          end
        end
        if (k == 2) begin
          n_checks++;
          if ({rd_o, wr_o, den_o, dtr_o, ad_oe_o} !== {wr, !wr, 1'b0, wr, wr}) begin
            n_fail++; $display("FAIL rnd_t2[%0d] got=%b exp=%b", it, {rd_o, wr_o, den_o, dtr_o, ad_oe_o}, {wr, !wr, 1'b0, wr, wr});
          end
          if (wr) begin
            n_checks++;
            if (ad_do_o !== wd) begin
              n_fail++; $display("FAIL rnd_ad_do[%0d] got=%h exp=%h", it, ad_do_o, wd);
            end
          end
        end
        if (eu_ack_o && ack_at < 0) begin
          ack_at = k;
          eu_req = 0;
          if (!wr) model_rdata = di;
          n_checks++;
          if (eu_rdata_o !== model_rdata) begin
            n_fail++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", it, eu_rdata_o, model_rdata);
          end
        end
      end
      eu_req = 0; ready = 1;
      n_checks++;
      if (ack_at !== 4 + w) begin
        n_fail++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", it, ack_at, 4 + w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_eu_read();
    test_prefetch();
    test_wait_write();
    test_hold_fetch();
    test_intr();
    test_flush();
    test_random_eu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
